// File: rtl/demux3_stream.sv
// demux3_stream: steers one producer stream to one of three consumer streams.
// The 2-bit select travels with each transfer. One registered stage sits
// between producer and consumers and sustains one transfer per clock.
// Select code 11 is illegal: the transfer is accepted, discarded and counted.
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_s_valid / o_s_ready     producer handshake (o_s_ready is combinational)
//   i_s_data, i_s_sel         producer payload and destination (00/01/10)
//   o_m0/1/2_valid            consumer valids, at most one high at a time
//   i_m0/1/2_ready            consumer readys
//   o_m_data                  shared payload register, held after delivery
//   o_drop_pulse              one-cycle pulse after an illegal-select transfer
//   o_drop_cnt                saturating count of discarded transfers
module demux3_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [WIDTH-1:0] i_s_data,
    input  logic [1:0]       i_s_sel,
    output logic             o_m0_valid,
    input  logic             i_m0_ready,
    output logic             o_m1_valid,
    input  logic             i_m1_ready,
    output logic             o_m2_valid,
    input  logic             i_m2_ready,
    output logic [WIDTH-1:0] o_m_data,
    output logic             o_drop_pulse,
    output logic [CNT_W-1:0] o_drop_cnt
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    logic [1:0]         r_sel;
    logic [2:0]         r_valid;
    logic [WIDTH-1:0]   r_data;
    logic               r_drop_pulse;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_out_fire;
    logic               w_in_fire;
    logic               w_legal;
    logic               w_drop;

    // Readys are masked by the one-hot valid register, so a ready on an idle
    // consumer never counts as a delivery.
    assign w_out_fire = (r_valid[0] & i_m0_ready) |
                        (r_valid[1] & i_m1_ready) |
                        (r_valid[2] & i_m2_ready);

    // Free slot, or the held word leaves on this same edge (no bubble).
    assign o_s_ready  = (r_state == ST_EMPTY) | w_out_fire;
    assign w_in_fire  = i_s_valid & o_s_ready;
    assign w_legal    = (i_s_sel != 2'b11);
    assign w_drop     = w_in_fire & ~w_legal;

    // Holding stage: load on legal accept, empty on delivery, else hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
            r_sel   <= 2'b00;
            r_valid <= 3'b000;
            r_data  <= '0;
        end else if (w_in_fire && w_legal) begin
            r_state <= ST_FULL;
            r_sel   <= i_s_sel;
            r_valid <= 3'(3'b001 << i_s_sel);
            r_data  <= i_s_data;
        end else if (w_out_fire) begin
            // Payload is kept; only the valids drop.
            r_state <= ST_EMPTY;
            r_valid <= 3'b000;
        end
    end

    // Drop reporting: pulse and saturating counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_drop_pulse <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_drop_pulse <= w_drop;
            if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign o_m0_valid   = r_valid[0];
    assign o_m1_valid   = r_valid[1];
    assign o_m2_valid   = r_valid[2];
    assign o_m_data     = r_data;
    assign o_drop_pulse = r_drop_pulse;
    assign o_drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_demux3_stream.sv
// tb_demux3_stream: directed stimulus with a queue-based scoreboard for
// demux3_stream. A second instance with a 2-bit counter shares all inputs
// to exercise drop-counter saturation.
module tb_demux3_stream;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic [1:0] s_sel;
    logic       m0_valid, m1_valid, m2_valid;
    logic       m0_ready, m1_ready, m2_ready;
    logic [7:0] m_data;
    logic       drop_pulse;
    logic [7:0] drop_cnt;

    logic       s_ready_b;
    logic       m0_valid_b, m1_valid_b, m2_valid_b;
    logic [7:0] m_data_b;
    logic       drop_pulse_b;
    logic [1:0] drop_cnt_b;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_out_cyc = 0;

    logic [9:0] q_out[$];
    logic [7:0] q_drop[$];

    demux3_stream #(.WIDTH(8), .CNT_W(8)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_valid(s_valid), .o_s_ready(s_ready),
        .i_s_data(s_data), .i_s_sel(s_sel),
        .o_m0_valid(m0_valid), .i_m0_ready(m0_ready),
        .o_m1_valid(m1_valid), .i_m1_ready(m1_ready),
        .o_m2_valid(m2_valid), .i_m2_ready(m2_ready),
        .o_m_data(m_data), .o_drop_pulse(drop_pulse), .o_drop_cnt(drop_cnt)
    );

    demux3_stream #(.WIDTH(8), .CNT_W(2)) u_dut_small (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_s_valid(s_valid), .o_s_ready(s_ready_b),
        .i_s_data(s_data), .i_s_sel(s_sel),
        .o_m0_valid(m0_valid_b), .i_m0_ready(m0_ready),
        .o_m1_valid(m1_valid_b), .i_m1_ready(m1_ready),
        .o_m2_valid(m2_valid_b), .i_m2_ready(m2_ready),
        .o_m_data(m_data_b), .o_drop_pulse(drop_pulse_b), .o_drop_cnt(drop_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every delivery and every drop pulse.
    always @(negedge clk) begin
        logic       fired;
        logic [1:0] port;
        logic [9:0] e;
        fired = 1'b0;
        port  = 2'd0;
        if (m0_valid | m1_valid | m2_valid)
            chk("valid_onehot", 32'($countones({m2_valid, m1_valid, m0_valid})), 32'd1);
        if (m0_valid && m0_ready) begin fired = 1'b1; port = 2'd0; end
        else if (m1_valid && m1_ready) begin fired = 1'b1; port = 2'd1; end
        else if (m2_valid && m2_ready) begin fired = 1'b1; port = 2'd2; end
        if (fired) begin
            chk("out_expected", 32'(q_out.size() != 0), 32'd1);
            if (q_out.size() != 0) begin
                e = q_out.pop_front();
                chk("out_port", 32'(port), 32'(e[9:8]));
                chk("out_data", 32'(m_data), 32'(e[7:0]));
            end
            last_out_cyc = cyc;
        end
        if (drop_pulse) begin
            chk("drop_expected", 32'(q_drop.size() != 0), 32'd1);
            if (q_drop.size() != 0) void'(q_drop.pop_front());
        end
    end

    // Present one word until accepted; push its expectation at acceptance.
    task automatic send(input logic [7:0] d, input logic [1:0] s, output int fire_cyc);
        int   n;
        logic rdy;
        s_valid  = 1'b1;
        s_data   = d;
        s_sel    = s;
        n        = 0;
        rdy      = 1'b0;
        fire_cyc = -1;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = s_ready;
            if (rdy) begin
                fire_cyc = cyc;
                if (s != 2'b11) q_out.push_back({s, d});
                else            q_drop.push_back(d);
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_accepted", 32'(rdy), 32'd1);
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int t0, tf;
        rst_n    = 1'b0;
        s_valid  = 1'b1;
        s_data   = 8'hEE;
        s_sel    = 2'b00;
        m0_ready = 1'b1;
        m1_ready = 1'b1;
        m2_ready = 1'b1;

        // Reset held with s_valid high
        repeat (3) @(negedge clk);
        chk("rst_valids", 32'({m2_valid, m1_valid, m0_valid}), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        s_valid = 1'b0;
        rst_n   = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        chk("post_rst_valids", 32'({m2_valid, m1_valid, m0_valid}), 32'd0);

        // Routing to each consumer, one per clock
        send(8'h11, 2'b00, t0);
        send(8'h22, 2'b01, tf);
        send(8'h33, 2'b10, tf);
        idle(3);
        chk("route_latency", 32'(last_out_cyc - t0), 32'd3);

        // Backpressure on m1 while m0 is ready; next word must wait
        m1_ready = 1'b0;
        send(8'h5A, 2'b01, tf);
        fork
            send(8'h77, 2'b00, tf);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_s_ready", 32'(s_ready), 32'd0);
                    chk("bp_m_data", 32'(m_data), 32'h5A);
                    chk("bp_m1_valid", 32'(m1_valid), 32'd1);
                    chk("bp_m0_valid", 32'(m0_valid), 32'd0);
                end
                @(posedge clk);
                #1;
                m1_ready = 1'b1;
            end
        join
        idle(3);
        chk("bp_drained", 32'(q_out.size()), 32'd0);

        // Back-to-back stream of 16 words alternating m0/m2
        for (int i = 0; i < 16; i++) begin
            int fc;
            send(8'(8'h80 + i), (i % 2 == 1) ? 2'b10 : 2'b00, fc);
            if (i == 0) t0 = fc;
        end
        idle(3);
        chk("b2b_span", 32'(last_out_cyc - t0), 32'd16);
        chk("b2b_drained", 32'(q_out.size()), 32'd0);

        // Illegal selects: dropped, counted, saturating in the 2-bit instance
        for (int i = 0; i < 3; i++) send(8'hDD, 2'b11, tf);
        idle(2);
        chk("drop_cnt_3", 32'(drop_cnt), 32'd3);
        chk("drop_cnt_small_3", 32'(drop_cnt_b), 32'd3);
        chk("drop_pulse_idle", 32'(drop_pulse), 32'd0);
        chk("drop_no_valid", 32'({m2_valid, m1_valid, m0_valid}), 32'd0);
        for (int i = 0; i < 2; i++) send(8'hDE, 2'b11, tf);
        idle(2);
        chk("drop_cnt_5", 32'(drop_cnt), 32'd5);
        chk("drop_cnt_small_sat", 32'(drop_cnt_b), 32'd3);
        chk("drop_q_empty", 32'(q_drop.size()), 32'd0);

        // Async reset while holding a word for m2
        m2_ready = 1'b0;
        send(8'h9C, 2'b10, tf);
        @(negedge clk);
        chk("hold_m2_valid", 32'(m2_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_m2_valid", 32'(m2_valid), 32'd0);
        chk("async_m_data", 32'(m_data), 32'd0);
        chk("async_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("async_s_ready", 32'(s_ready), 32'd1);
        q_out.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m2_ready = 1'b1;
        send(8'h42, 2'b10, t0);
        idle(3);
        chk("after_rst_latency", 32'(last_out_cyc - t0), 32'd1);
        chk("final_q_out", 32'(q_out.size()), 32'd0);
        chk("final_q_drop", 32'(q_drop.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
